// File: rtl/iq_upconverter.sv
// Transmit I/Q upconverter: buffers baseband samples, mixes them onto a quadrant NCO
// carrier and converts the result to a 1-bit stream with a first-order sigma-delta.
module iq_upconverter #(
    parameter int IQ_WIDTH    = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int RATE        = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PHASE_WIDTH-1:0] freq,
    input  logic [IQ_WIDTH-1:0]    i_data,
    input  logic [IQ_WIDTH-1:0]    q_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear_underrun,
    output logic                   rf_out,
    output logic [1:0]             phase_out,
    output logic                   underrun
);

    localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int MW = IQ_WIDTH + 1;
    localparam int AW = IQ_WIDTH + 3;
    localparam logic [CW-1:0] LAST_COUNT = CW'(RATE - 1);
    localparam logic signed [AW-1:0] FS_A = AW'(1 << (IQ_WIDTH - 1));

    logic [PHASE_WIDTH-1:0]     r_phase;
    logic [CW-1:0]              r_count;
    logic [IQ_WIDTH-1:0]        r_next_i;
    logic [IQ_WIDTH-1:0]        r_next_q;
    logic                       r_next_valid;
    logic signed [IQ_WIDTH-1:0] r_cur_i;
    logic signed [IQ_WIDTH-1:0] r_cur_q;
    logic signed [MW-1:0]       r_mix;
    logic signed [AW-1:0]       r_acc;
    logic                       r_rf;
    logic                       r_underrun;

    logic                       w_strobe;
    logic                       w_xfer;
    logic [1:0]                 w_quad;
    logic signed [MW-1:0]       w_cur_i_ext;
    logic signed [MW-1:0]       w_cur_q_ext;
    logic signed [MW-1:0]       w_mix_d;
    logic signed [AW-1:0]       w_fb;
    logic signed [AW-1:0]       w_err;

    // Handshake: a sample transfers on any rising edge where in_valid && in_ready.
    // in_ready depends only on the buffer state and reset, never on in_valid.
    assign in_ready  = !r_next_valid && !reset;
    assign w_xfer    = in_valid && in_ready;
    assign w_strobe  = (r_count == LAST_COUNT);
    assign w_quad    = r_phase[PHASE_WIDTH-1 -: 2];
    assign phase_out = w_quad;
    assign rf_out    = r_rf;
    assign underrun  = r_underrun;

    // One extra bit so that negating -FS gives +FS without wrapping.
    assign w_cur_i_ext = {r_cur_i[IQ_WIDTH-1], r_cur_i};
    assign w_cur_q_ext = {r_cur_q[IQ_WIDTH-1], r_cur_q};

    always_comb begin
        w_mix_d = w_cur_i_ext;
        case (w_quad)
            2'd0:    w_mix_d = w_cur_i_ext;
            2'd1:    w_mix_d = -w_cur_q_ext;
            2'd2:    w_mix_d = -w_cur_i_ext;
            default: w_mix_d = w_cur_q_ext;
        endcase
    end

    assign w_fb  = r_rf ? FS_A : -FS_A;
    assign w_err = r_acc + {{2{r_mix[MW-1]}}, r_mix} - w_fb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_count <= '0;
        end else begin
            r_phase <= r_phase + freq;
            r_count <= w_strobe ? '0 : r_count + CW'(1);
        end
    end

    // A sample accepted on the strobe edge lands in the buffer and waits for the next strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_i     <= '0;
            r_next_q     <= '0;
            r_next_valid <= 1'b0;
            r_cur_i      <= '0;
            r_cur_q      <= '0;
        end else begin
            if (w_xfer) begin
                r_next_i     <= i_data;
                r_next_q     <= q_data;
                r_next_valid <= 1'b1;
            end else if (w_strobe) begin
                r_next_valid <= 1'b0;
            end
            if (w_strobe) begin
                if (r_next_valid) begin
                    r_cur_i <= r_next_i;
                    r_cur_q <= r_next_q;
                end else begin
                    r_cur_i <= '0;
                    r_cur_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_strobe && !r_next_valid) begin
            r_underrun <= 1'b1;
        end else if (clear_underrun) begin
            r_underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mix <= '0;
            r_acc <= '0;
            r_rf  <= 1'b0;
        end else begin
            r_mix <= w_mix_d;
            r_acc <= w_err;
            r_rf  <= !w_err[AW-1];
        end
    end

endmodule

// File: tb/tb_iq_upconverter.sv
// Bench for iq_upconverter: integer reference model checked every cycle, plus
// directed NCO, density, underrun and back-pressure scenarios with literal expectations.
module tb_iq_upconverter;

    localparam int W    = 8;
    localparam int PW   = 32;
    localparam int RATE = 256;
    localparam int FS   = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] freq = '0;
    logic [W-1:0]  i_data = '0;
    logic [W-1:0]  q_data = '0;
    logic          in_valid = 1'b0;
    logic          clear_underrun = 1'b0;
    logic          in_ready;
    logic          rf_out;
    logic [1:0]    phase_out;
    logic          underrun;

    iq_upconverter #(.IQ_WIDTH(W), .PHASE_WIDTH(PW), .RATE(RATE)) dut (
        .clk(clk),
        .reset(reset),
        .freq(freq),
        .i_data(i_data),
        .q_data(q_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .clear_underrun(clear_underrun),
        .rf_out(rf_out),
        .phase_out(phase_out),
        .underrun(underrun)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_range(input string name, input longint act,
                                        input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endfunction

    // Reference model: plain integers, the buffered sample kept in exp_q.
    bit            check_en = 1'b0;
    bit [PW-1:0]   m_phase;
    int            m_cycle;
    int            m_cur_i, m_cur_q;
    int            m_mix, m_acc;
    bit            m_rf, m_und;
    logic [2*W-1:0] exp_q[$];

    function automatic int quad(input bit [PW-1:0] p);
        return int'(p >> (PW - 2));
    endfunction

    task automatic model_step();
        int fb, e, nm;
        bit strobe, xfer, set_u;
        logic [2*W-1:0] s;
        logic [W-1:0] si, sq;
        if (reset) begin
            check_en = 1'b1;
            m_phase = '0; m_cycle = 0; m_cur_i = 0; m_cur_q = 0;
            m_mix = 0; m_acc = 0; m_rf = 1'b0; m_und = 1'b0;
            exp_q.delete();
        end else begin
            xfer   = in_valid && (exp_q.size() == 0);
            strobe = (m_cycle % RATE) == RATE - 1;
            fb = m_rf ? FS : -FS;
            e  = m_acc + m_mix - fb;
            m_acc = e;
            m_rf  = (e >= 0);
            case (quad(m_phase))
                0:       nm = m_cur_i;
                1:       nm = -m_cur_q;
                2:       nm = -m_cur_i;
                default: nm = m_cur_q;
            endcase
            m_mix   = nm;
            m_phase = m_phase + freq;
            set_u   = 1'b0;
            if (strobe) begin
                if (exp_q.size() != 0) begin
                    s  = exp_q.pop_front();
                    si = s[2*W-1:W];
                    sq = s[W-1:0];
                    m_cur_i = int'($signed(si));
                    m_cur_q = int'($signed(sq));
                end else begin
                    m_cur_i = 0;
                    m_cur_q = 0;
                    set_u   = 1'b1;
                end
            end
            if (xfer) exp_q.push_back({i_data, q_data});
            if (set_u) m_und = 1'b1;
            else if (clear_underrun) m_und = 1'b0;
            m_cycle++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison, away from the active edge
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("in_ready", in_ready, (exp_q.size() == 0) && !reset);
            check("phase_out", phase_out, quad(m_phase));
            check("rf_out", rf_out, m_rf);
            check("underrun", underrun, m_und);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(rf_out);
        end
    endtask

    task automatic nco_seq(input logic [PW-1:0] f, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
        int exp_v[5];
        exp_v = '{e0, e1, e2, e3, e4};
        freq = f;
        in_valid = 1'b0;
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("nco_seq", phase_out, exp_v[k]);
        end
    endtask

    task automatic dens_run(input string name, input logic [PW-1:0] f, input logic [W-1:0] iv,
                            input logic [W-1:0] qv, input int win, input int lo, input int hi);
        int ones;
        freq = f;
        i_data = iv;
        q_data = qv;
        in_valid = 1'b1;
        do_reset(2);
        repeat (600) tick();
        count_ones(win, ones);
        check_range(name, ones, lo, hi);
        in_valid = 1'b0;
    endtask

    initial begin
        int ones, lo_cnt, guard, n_hs, k;
        bit hs;

        // Reset held 3 clocks with traffic offered
        freq = 32'h4000_0000;
        in_valid = 1'b1;
        i_data = 8'd5;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_rf_out", rf_out, 0);
        check("rst_phase", phase_out, 0);
        check("rst_underrun", underrun, 0);
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_phase", phase_out, 1);

        // NCO quadrant sequences
        nco_seq(32'h4000_0000, 0, 1, 2, 3, 0);
        nco_seq(32'h8000_0000, 0, 2, 0, 2, 0);
        nco_seq(32'h0000_0000, 0, 0, 0, 0, 0);

        // DC and quadrature ones density
        dens_run("dc_p64",   32'h0,          8'd64,  8'd0,   256, 191, 193);
        dens_run("dc_m128",  32'h0,          8'h80,  8'd0,   256, 0,   0);
        dens_run("dc_p127",  32'h0,          8'd127, 8'd0,   256, 255, 256);
        dens_run("quad_neg", 32'h8000_0000,  8'h80,  8'd0,   256, 127, 129);
        dens_run("quad_iq",  32'h4000_0000,  8'd100, 8'd100, 1024, 511, 513);

        // Single sample, then starve
        freq = 32'h0;
        i_data = 8'd100;
        q_data = 8'd0;
        in_valid = 1'b1;
        do_reset(2);
        tick();
        in_valid = 1'b0;
        lo_cnt = 0;
        guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            if (in_ready) break;
            lo_cnt++;
            guard++;
        end
        check_range("ready_low_clocks", lo_cnt, 1, 256);
        guard = 0;
        while (!underrun && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("underrun_set", underrun, 1);
        repeat (20) tick();
        count_ones(256, ones);
        check_range("idle_density", ones, 127, 129);
        guard = 0;
        while ((m_cycle % RATE) != 100 && guard < 300) begin
            tick();
            guard++;
        end
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        @(negedge clk);
        check("underrun_clear", underrun, 0);
        guard = 0;
        while ((m_cycle % RATE) != RATE - 1 && guard < 300) begin
            tick();
            guard++;
        end
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        @(negedge clk);
        check("underrun_set_wins", underrun, 1);

        // Back-pressure: valid always high, incrementing I
        freq = 32'h1234_5679;
        k = 0;
        i_data = '0;
        q_data = W'($urandom);
        in_valid = 1'b1;
        do_reset(2);
        n_hs = 0;
        repeat (1024) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) begin
                n_hs++;
                k++;
                i_data = W'(k);
                q_data = W'($urandom);
            end
        end
        check("xfer_count", n_hs, 4);
        @(negedge clk);
        check("bp_no_underrun", underrun, 0);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_phase", phase_out, 0);
        check("mid_rst_rf", rf_out, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_ready", in_ready, 0);
        reset = 1'b0;
        in_valid = 1'b0;

        // Randomized traffic
        freq = $urandom;
        do_reset(2);
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 99) < 3) freq = $urandom;
            in_valid = ($urandom_range(0, 179) == 0);
            i_data = W'($urandom);
            q_data = W'($urandom);
            clear_underrun = ($urandom_range(0, 63) == 0);
            reset = (c % 3000 == 2999);
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        clear_underrun = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
